char_buffer_writer: RTL and testbench
=====================================

CHAR_BUFFER_WRITER -- requirements
Module: char_buffer_writer

Interface
REQ-001 Parameter ROWS, default 24: number of text rows on screen.
REQ-002 Parameter COLS, default 80: number of text columns on screen.
REQ-003 Parameter ROW_BITS, default 5: cursor row width.
REQ-004 Parameter COL_BITS, default 7: cursor column width.
REQ-005 Parameter ADDR_BITS, default 11: char buffer address width. Buffer size is ROWS*COLS cells.
REQ-006 clk  in  1  single clock; all logic is posedge clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 data  in  8  incoming terminal byte.
REQ-009 valid  in  1  data is valid this cycle.
REQ-010 ready  out  1  writer can accept a byte; transfer occurs on posedge when valid && ready.
REQ-011 buffer_waddr  out  ADDR_BITS  char buffer write address.
REQ-012 buffer_din  out  8  char buffer write data.
REQ-013 buffer_wen  out  1  char buffer write strobe, one cell per cycle.
REQ-014 buffer_first_char  out  ADDR_BITS  buffer address of screen row 0 (scroll base).
REQ-015 buffer_first_char_wen  out  1  one-cycle strobe that loads buffer_first_char.
REQ-016 new_cursor_x  out  COL_BITS  cursor column.
REQ-017 new_cursor_y  out  ROW_BITS  cursor row.
REQ-018 new_cursor_wen  out  1  one-cycle strobe on any cursor change.

Function
REQ-019 All outputs shall be registered; effects appear the cycle after acceptance.
REQ-020 Cell address shall be (first_char + y*COLS + x) computed at ADDR_BITS+1 width, minus ROWS*COLS when the sum is >= ROWS*COLS.
REQ-021 FSM states shall be CLEAR_ALL, IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR.
REQ-022 Bytes 0x20..0x7E in IDLE: write byte at cursor; x = min(x+1, COLS-1); no auto-wrap.
REQ-023 0x0D (CR) shall set x=0.
REQ-024 0x08 (BS) shall set x=max(x-1,0).
REQ-025 0x0A (LF): if y<ROWS-1, y=y+1. Otherwise scroll: first_char += COLS (wrapping to 0 at ROWS*COLS) with buffer_first_char_wen pulsed, then CLEAR the new bottom row (COLS writes of 0x20); y is unchanged.
REQ-026 0x1B shall enter ESC; any other control byte is ignored in IDLE.
REQ-027 ESC + 'A'/'B'/'C'/'D' shall move the cursor up/down/right/left by one, saturating at screen edges. 'H' shall home the cursor (0,0).
REQ-028 ESC + 'J' shall CLEAR from the cursor to the end of the screen; ESC + 'K' shall CLEAR from the cursor to the end of the line. The cursor is unchanged.
REQ-029 ESC + 'Y' shall enter ESC_Y_ROW. The next byte minus 0x20 is the row; the byte after that minus 0x20 is the column. Each value is clamped to ROWS-1 / COLS-1 (values below 0x20 clamp to 0). The cursor is set after the column byte.
REQ-030 Any other byte in ESC shall return to IDLE with no effect.
REQ-031 CLEAR shall write 0x20 to one cell per cycle with a wrapping address. ready shall be low from the cycle after the triggering byte until the cycle after the last write.
REQ-032 new_cursor_wen shall pulse only when x or y actually changes value.
REQ-033 ready shall be high in IDLE, ESC, ESC_Y_ROW and ESC_Y_COL; all single-cycle operations accept back-to-back bytes.

Reset
REQ-034 On reset assert: ready=0, buffer_wen=0, buffer_first_char=0, buffer_first_char_wen=0, new_cursor_x=0, new_cursor_y=0, new_cursor_wen=0, buffer_waddr=0, buffer_din=0, state=CLEAR_ALL.
REQ-035 After reset release, CLEAR_ALL shall write 0x20 to all ROWS*COLS cells (addresses 0..ROWS*COLS-1). It shall pulse new_cursor_wen once with (0,0), then enter IDLE with ready=1.
REQ-036 Reset asserted mid-CLEAR or mid-escape shall abort the operation and restart at CLEAR_ALL.

Verification
REQ-037 Reset, wait for ready. Required: exactly 1920 writes of 0x20 at addresses 0..1919, then ready=1 and cursor (0,0).
REQ-038 Send 'A','B' back-to-back. Required: writes 0x41@0 and 0x42@1, cursor x=2, ready never drops.
REQ-039 Send ESC 'Y' 0x37 0x45. Required: cursor (23,37); then 'Z' writes 0x5A at address 1877.
REQ-040 Cursor at y=23, send LF. Required: first_char=80 with one strobe, 80 writes of 0x20 at addresses 0..79, ready low for 80 cycles, y remains 23.
REQ-041 first_char=1840, cursor (1,78), send ESC 'K'. Required: 2 writes at addresses 78 and 79 (wrapped); cursor unchanged.
REQ-042 Send 0x08 at x=0, ESC 'A' at y=0, and ESC 'Q'. Required: no cursor change, no new_cursor_wen, no writes.

Source files
------------

// File: rtl/char_buffer_writer_if.sv
// Bundles the byte input handshake and the char buffer / cursor outputs of the terminal writer.
// The writer uses the slave modport; whoever feeds bytes and consumes outputs uses master.
interface char_buffer_writer_if #(
   parameter int ADDR_BITS = 11,
   parameter int ROW_BITS  = 5,
   parameter int COL_BITS  = 7
);
   logic [7:0]           data;
   logic                 valid;
   logic                 ready;
   logic [ADDR_BITS-1:0] buffer_waddr;
   logic [7:0]           buffer_din;
   logic                 buffer_wen;
   logic [ADDR_BITS-1:0] buffer_first_char;
   logic                 buffer_first_char_wen;
   logic [COL_BITS-1:0]  new_cursor_x;
   logic [ROW_BITS-1:0]  new_cursor_y;
   logic                 new_cursor_wen;

   modport master (
      output data, valid,
      input  ready, buffer_waddr, buffer_din, buffer_wen, buffer_first_char,
             buffer_first_char_wen, new_cursor_x, new_cursor_y, new_cursor_wen
   );

   modport slave (
      input  data, valid,
      output ready, buffer_waddr, buffer_din, buffer_wen, buffer_first_char,
             buffer_first_char_wen, new_cursor_x, new_cursor_y, new_cursor_wen
   );
endinterface

// File: rtl/char_buffer_writer.sv
// Terminal byte interpreter: writes printable bytes into a circular character buffer,
// handles CR/BS/LF with scrolling and a small VT52-style escape set, all outputs registered.
module char_buffer_writer #(
   parameter int ROWS      = 24,
   parameter int COLS      = 80,
   parameter int ROW_BITS  = 5,
   parameter int COL_BITS  = 7,
   parameter int ADDR_BITS = 11
) (
   input logic clk,
   input logic reset,
   char_buffer_writer_if.slave bus
);

   localparam int AW1 = ADDR_BITS + 1;
   localparam logic [AW1-1:0]       TOTAL     = AW1'(ROWS * COLS);
   localparam logic [AW1-1:0]       COLS_W    = AW1'(COLS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ROWS * COLS - 1);
   localparam logic [ROW_BITS-1:0]  MAX_ROW   = ROW_BITS'(ROWS - 1);
   localparam logic [COL_BITS-1:0]  MAX_COL   = COL_BITS'(COLS - 1);
   localparam logic [7:0]           SPACE     = 8'h20;

   typedef enum logic [2:0] {CLEAR_ALL, IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR} state_t;

   state_t               state_q, state_d;
   logic [COL_BITS-1:0]  x_q, x_d;
   logic [ROW_BITS-1:0]  y_q, y_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [ADDR_BITS-1:0] fc_q, fc_d;
   logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
   logic [AW1-1:0]       clr_cnt_q, clr_cnt_d;
   logic                 ready_q, ready_d;
   logic                 wen_q, wen_d;
   logic [ADDR_BITS-1:0] waddr_q, waddr_d;
   logic [7:0]           din_q, din_d;
   logic                 fc_wen_q, fc_wen_d;
   logic                 cursor_wen_q, cursor_wen_d;

   logic                 accept;
   logic                 force_cursor;
   logic [ADDR_BITS-1:0] cursor_addr;
   logic [AW1-1:0]       fc_sum;
   logic [ADDR_BITS-1:0] next_fc;
   logic [ADDR_BITS-1:0] scroll_start;

   // Screen position to buffer cell, folding once around the end of the circular buffer.
   function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [ADDR_BITS-1:0] fc,
                                                      input logic [ROW_BITS-1:0]  y,
                                                      input logic [COL_BITS-1:0]  x);
      logic [AW1-1:0] sum;
      sum = {1'b0, fc} + AW1'(y) * COLS_W + AW1'(x);
      if (sum >= TOTAL) sum = sum - TOTAL;
      return sum[ADDR_BITS-1:0];
   endfunction

   function automatic logic [ROW_BITS-1:0] clamp_row(input logic [7:0] b);
      logic [7:0] v;
      v = b - SPACE;
      if (b < SPACE) return '0;
      else if (v > 8'(ROWS - 1)) return MAX_ROW;
      else return v[ROW_BITS-1:0];
   endfunction

   function automatic logic [COL_BITS-1:0] clamp_col(input logic [7:0] b);
      logic [7:0] v;
      v = b - SPACE;
      if (b < SPACE) return '0;
      else if (v > 8'(COLS - 1)) return MAX_COL;
      else return v[COL_BITS-1:0];
   endfunction

   assign accept       = bus.valid && ready_q;
   assign cursor_addr  = cell_addr(fc_q, y_q, x_q);
   assign fc_sum       = {1'b0, fc_q} + COLS_W;
   assign next_fc      = (fc_sum >= TOTAL) ? '0 : fc_sum[ADDR_BITS-1:0];
   assign scroll_start = cell_addr(next_fc, MAX_ROW, '0);

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      row_d        = row_q;
      fc_d         = fc_q;
      clr_addr_d   = clr_addr_q;
      clr_cnt_d    = clr_cnt_q;
      ready_d      = ready_q;
      wen_d        = 1'b0;
      waddr_d      = waddr_q;
      din_d        = din_q;
      fc_wen_d     = 1'b0;
      force_cursor = 1'b0;

      case (state_q)
         CLEAR_ALL, CLEAR: begin
            wen_d      = 1'b1;
            waddr_d    = clr_addr_q;
            din_d      = SPACE;
            clr_addr_d = (clr_addr_q == LAST_ADDR) ? '0 : clr_addr_q + ADDR_BITS'(1);
            clr_cnt_d  = clr_cnt_q - AW1'(1);
            if (clr_cnt_q == AW1'(1)) begin
               state_d = IDLE;
               ready_d = 1'b1;
               if (state_q == CLEAR_ALL) begin
                  x_d          = '0;
                  y_d          = '0;
                  force_cursor = 1'b1;
               end
            end
         end

         IDLE: if (accept) begin
            if (bus.data >= 8'h20 && bus.data <= 8'h7E) begin
               wen_d   = 1'b1;
               waddr_d = cursor_addr;
               din_d   = bus.data;
               if (x_q < MAX_COL) x_d = x_q + COL_BITS'(1);
            end else begin
               case (bus.data)
                  8'h0D: x_d = '0;
                  8'h08: if (x_q != '0) x_d = x_q - COL_BITS'(1);
                  8'h0A: begin
                     if (y_q < MAX_ROW) begin
                        y_d = y_q + ROW_BITS'(1);
                     end else begin
                        // Scroll: the old top row becomes the new, blank bottom row.
                        fc_d       = next_fc;
                        fc_wen_d   = 1'b1;
                        state_d    = CLEAR;
                        ready_d    = 1'b0;
                        clr_addr_d = scroll_start;
                        clr_cnt_d  = COLS_W;
                     end
                  end
                  8'h1B:   state_d = ESC;
                  default: ;
               endcase
            end
         end

         ESC: if (accept) begin
            state_d = IDLE;
            case (bus.data)
               8'h41: if (y_q != '0) y_d = y_q - ROW_BITS'(1);
               8'h42: if (y_q < MAX_ROW) y_d = y_q + ROW_BITS'(1);
               8'h43: if (x_q < MAX_COL) x_d = x_q + COL_BITS'(1);
               8'h44: if (x_q != '0) x_d = x_q - COL_BITS'(1);
               8'h48: begin
                  x_d = '0;
                  y_d = '0;
               end
               8'h4A: begin
                  state_d    = CLEAR;
                  ready_d    = 1'b0;
                  clr_addr_d = cursor_addr;
                  clr_cnt_d  = TOTAL - (AW1'(y_q) * COLS_W + AW1'(x_q));
               end
               8'h4B: begin
                  state_d    = CLEAR;
                  ready_d    = 1'b0;
                  clr_addr_d = cursor_addr;
                  clr_cnt_d  = COLS_W - AW1'(x_q);
               end
               8'h59:   state_d = ESC_Y_ROW;
               default: ;
            endcase
         end

         ESC_Y_ROW: if (accept) begin
            row_d   = clamp_row(bus.data);
            state_d = ESC_Y_COL;
         end

         ESC_Y_COL: if (accept) begin
            x_d     = clamp_col(bus.data);
            y_d     = row_q;
            state_d = IDLE;
         end

         default: state_d = CLEAR_ALL;
      endcase

      cursor_wen_d = force_cursor || (x_d != x_q) || (y_d != y_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CLEAR_ALL;
         x_q          <= '0;
         y_q          <= '0;
         row_q        <= '0;
         fc_q         <= '0;
         clr_addr_q   <= '0;
         clr_cnt_q    <= TOTAL;
         ready_q      <= 1'b0;
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         din_q        <= '0;
         fc_wen_q     <= 1'b0;
         cursor_wen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         row_q        <= row_d;
         fc_q         <= fc_d;
         clr_addr_q   <= clr_addr_d;
         clr_cnt_q    <= clr_cnt_d;
         ready_q      <= ready_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         din_q        <= din_d;
         fc_wen_q     <= fc_wen_d;
         cursor_wen_q <= cursor_wen_d;
      end
   end

   assign bus.ready                 = ready_q;
   assign bus.buffer_wen            = wen_q;
   assign bus.buffer_waddr          = waddr_q;
   assign bus.buffer_din            = din_q;
   assign bus.buffer_first_char     = fc_q;
   assign bus.buffer_first_char_wen = fc_wen_q;
   assign bus.new_cursor_x          = x_q;
   assign bus.new_cursor_y          = y_q;
   assign bus.new_cursor_wen        = cursor_wen_q;

endmodule

// File: tb/tb_char_buffer_writer.sv
// Scoreboard bench for char_buffer_writer: expected writes, cursor updates and scroll-base
// loads are queued as bytes are sent and popped as the writer's strobes appear.
module tb_char_buffer_writer;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   char_buffer_writer_if #(.ADDR_BITS(11), .ROW_BITS(5), .COL_BITS(7)) bus();

   char_buffer_writer #(
      .ROWS(24), .COLS(80), .ROW_BITS(5), .COL_BITS(7), .ADDR_BITS(11)
   ) dut (
      .clk(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct packed {
      logic [10:0] addr;
      logic [7:0]  din;
   } WriteExp;

   typedef struct packed {
      logic [6:0] x;
      logic [4:0] y;
   } CursorExp;

   WriteExp     writeQueue[$];
   CursorExp    cursorQueue[$];
   logic [10:0] firstCharQueue[$];
   WriteExp     monWrite;
   CursorExp    monCursor;
   logic [10:0] monFirstChar;

   int errors = 0;
   int checks = 0;
   int readyLowCycles = 0;

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   // Output monitor: every strobe must match the oldest pending expectation.
   always @(negedge clock) begin
      if (!reset) begin
         if (!bus.ready) readyLowCycles++;
         if (bus.buffer_wen) begin
            checkOutput("write_expected", 32'(writeQueue.size() != 0), 32'd1);
            if (writeQueue.size() != 0) begin
               monWrite = writeQueue.pop_front();
               checkOutput("write_addr", 32'(bus.buffer_waddr), 32'(monWrite.addr));
               checkOutput("write_data", 32'(bus.buffer_din), 32'(monWrite.din));
            end
         end
         if (bus.new_cursor_wen) begin
            checkOutput("cursor_expected", 32'(cursorQueue.size() != 0), 32'd1);
            if (cursorQueue.size() != 0) begin
               monCursor = cursorQueue.pop_front();
               checkOutput("cursor_x", 32'(bus.new_cursor_x), 32'(monCursor.x));
               checkOutput("cursor_y", 32'(bus.new_cursor_y), 32'(monCursor.y));
            end
         end
         if (bus.buffer_first_char_wen) begin
            checkOutput("first_char_expected", 32'(firstCharQueue.size() != 0), 32'd1);
            if (firstCharQueue.size() != 0) begin
               monFirstChar = firstCharQueue.pop_front();
               checkOutput("first_char", 32'(bus.buffer_first_char), 32'(monFirstChar));
            end
         end
      end
   end

   task automatic expectWrite(input int addr, input logic [7:0] din);
      WriteExp e;
      e.addr = 11'(addr);
      e.din  = din;
      writeQueue.push_back(e);
   endtask

   task automatic expectClear(input int start, input int count);
      for (int i = 0; i < count; i++) expectWrite((start + i) % 1920, 8'h20);
   endtask

   task automatic expectCursor(input int x, input int y);
      CursorExp c;
      c.x = 7'(x);
      c.y = 5'(y);
      cursorQueue.push_back(c);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      while (!bus.ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      if (!bus.ready) checkOutput("ready_timeout", 32'(bus.ready), 32'd1);
      bus.data  = b;
      bus.valid = 1'b1;
      @(posedge clock);
      #1;
      bus.valid = 1'b0;
   endtask

   task automatic sendEsc(input logic [7:0] b);
      applyStimulus(8'h1B);
      applyStimulus(b);
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!bus.ready && n < 5000) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, 32'(bus.ready), 32'd1);
   endtask

   task automatic checkDrained(input string tag);
      repeat (3) @(negedge clock);
      checkOutput({tag, "_writes_left"}, 32'(writeQueue.size()), 32'd0);
      checkOutput({tag, "_cursor_left"}, 32'(cursorQueue.size()), 32'd0);
      checkOutput({tag, "_scroll_left"}, 32'(firstCharQueue.size()), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready"}, 32'(bus.ready), 32'd0);
      checkOutput({tag, "_wen"}, 32'(bus.buffer_wen), 32'd0);
      checkOutput({tag, "_first_char"}, 32'(bus.buffer_first_char), 32'd0);
      checkOutput({tag, "_first_char_wen"}, 32'(bus.buffer_first_char_wen), 32'd0);
      checkOutput({tag, "_x"}, 32'(bus.new_cursor_x), 32'd0);
      checkOutput({tag, "_y"}, 32'(bus.new_cursor_y), 32'd0);
      checkOutput({tag, "_cursor_wen"}, 32'(bus.new_cursor_wen), 32'd0);
      checkOutput({tag, "_waddr"}, 32'(bus.buffer_waddr), 32'd0);
      checkOutput({tag, "_din"}, 32'(bus.buffer_din), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.data  = 8'h00;
      bus.valid = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      checkResetState("reset");

      // Power-up clear of the whole screen, then the home cursor announcement.
      expectClear(0, 1920);
      expectCursor(0, 0);
      reset = 1'b0;
      waitReady("init_ready");
      checkOutput("init_x", 32'(bus.new_cursor_x), 32'd0);
      checkOutput("init_y", 32'(bus.new_cursor_y), 32'd0);
      checkDrained("init");

      // Back-to-back printable bytes.
      readyLowCycles = 0;
      expectWrite(0, 8'h41);
      expectCursor(1, 0);
      expectWrite(1, 8'h42);
      expectCursor(2, 0);
      applyStimulus(8'h41);
      applyStimulus(8'h42);
      checkDrained("ab");
      checkOutput("ab_ready_low", 32'(readyLowCycles), 32'd0);
      checkOutput("ab_x", 32'(bus.new_cursor_x), 32'd2);

      // Direct cursor addressing, then a write at the addressed cell.
      expectCursor(37, 23);
      sendEsc(8'h59);
      applyStimulus(8'h37);
      applyStimulus(8'h45);
      repeat (2) @(negedge clock);
      checkOutput("escy_x", 32'(bus.new_cursor_x), 32'd37);
      checkOutput("escy_y", 32'(bus.new_cursor_y), 32'd23);
      expectWrite(1877, 8'h5A);
      expectCursor(38, 23);
      applyStimulus(8'h5A);
      checkDrained("escy");

      // LF on the bottom row scrolls and blanks the new bottom row.
      readyLowCycles = 0;
      firstCharQueue.push_back(11'd80);
      expectClear(0, 80);
      applyStimulus(8'h0A);
      waitReady("lf_ready");
      checkDrained("lf");
      checkOutput("lf_ready_low", 32'(readyLowCycles), 32'd80);
      checkOutput("lf_first_char", 32'(bus.buffer_first_char), 32'd80);
      checkOutput("lf_y", 32'(bus.new_cursor_y), 32'd23);

      // Scroll until the base sits at the last row of the buffer.
      for (int k = 2; k <= 23; k++) begin
         firstCharQueue.push_back(11'(k * 80));
         expectClear((k - 1) * 80, 80);
         applyStimulus(8'h0A);
         waitReady("scroll_ready");
      end
      checkDrained("scroll");
      checkOutput("scroll_first_char", 32'(bus.buffer_first_char), 32'd1840);

      // Erase to end of line across the buffer wrap point.
      expectCursor(78, 1);
      sendEsc(8'h59);
      applyStimulus(8'h21);
      applyStimulus(8'h6E);
      readyLowCycles = 0;
      expectClear(78, 2);
      sendEsc(8'h4B);
      waitReady("esck_ready");
      checkDrained("esck");
      checkOutput("esck_ready_low", 32'(readyLowCycles), 32'd2);
      checkOutput("esck_x", 32'(bus.new_cursor_x), 32'd78);
      checkOutput("esck_y", 32'(bus.new_cursor_y), 32'd1);

      // Saturating moves and ignored bytes must produce nothing at all.
      expectCursor(0, 0);
      sendEsc(8'h48);
      applyStimulus(8'h08);
      sendEsc(8'h41);
      sendEsc(8'h51);
      applyStimulus(8'h07);
      sendEsc(8'h44);
      checkDrained("noop");
      checkOutput("noop_x", 32'(bus.new_cursor_x), 32'd0);
      checkOutput("noop_y", 32'(bus.new_cursor_y), 32'd0);

      // Clamped ESC Y, printing in the last column, CR and the plain cursor moves.
      expectCursor(79, 0);
      sendEsc(8'h59);
      applyStimulus(8'h10);
      applyStimulus(8'h7E);
      expectWrite(1919, 8'h78);
      applyStimulus(8'h78);
      expectCursor(0, 0);
      applyStimulus(8'h0D);
      expectCursor(0, 1);
      applyStimulus(8'h0A);
      expectCursor(0, 2);
      sendEsc(8'h42);
      expectCursor(1, 2);
      sendEsc(8'h43);
      checkDrained("moves");
      checkOutput("moves_x", 32'(bus.new_cursor_x), 32'd1);
      checkOutput("moves_y", 32'(bus.new_cursor_y), 32'd2);

      // Erase to end of screen from the start of row 22.
      expectCursor(0, 22);
      sendEsc(8'h59);
      applyStimulus(8'h36);
      applyStimulus(8'h20);
      readyLowCycles = 0;
      expectClear(1680, 160);
      sendEsc(8'h4A);
      waitReady("escj_ready");
      checkDrained("escj");
      checkOutput("escj_ready_low", 32'(readyLowCycles), 32'd160);

      // Reset in the middle of a clear restarts from a blank screen with base 0.
      expectClear(1680, 160);
      sendEsc(8'h4A);
      repeat (20) @(negedge clock);
      @(posedge clock);
      #2;
      reset = 1'b1;
      writeQueue.delete();
      cursorQueue.delete();
      firstCharQueue.delete();
      @(negedge clock);
      checkResetState("midreset");
      expectClear(0, 1920);
      expectCursor(0, 0);
      reset = 1'b0;
      waitReady("midreset_ready");
      expectWrite(0, 8'h51);
      expectCursor(1, 0);
      applyStimulus(8'h51);
      checkDrained("midreset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
